// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweep stage.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefNIn = 4;
  localparam int unsigned HoldW  = 4;

  // F = A(B+CD) + BC', bit m is F for m = {A,B,C,D}
  localparam logic [15:0] GoldenAbcd = 16'hF830;

endpackage

// File: rtl/truth_sweep_if.sv
// Bus between the sweep stage and its environment: stimulus out, F back, results out.
interface truth_sweep_if #(
  parameter int unsigned N_IN = 4
) ();

  logic                 start;
  logic                 f_in;
  logic [N_IN-1:0]      vec_out;
  logic                 vec_valid;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   table_out;
  logic [N_IN:0]        err_cnt;
  logic [N_IN-1:0]      first_fail;

  modport master (
    output start, f_in,
    input  vec_out, vec_valid, busy, done, pass, table_out, err_cnt, first_fail
  );

  modport slave (
    input  start, f_in,
    output vec_out, vec_valid, busy, done, pass, table_out, err_cnt, first_fail
  );

endinterface

// File: rtl/sweep_counter.sv
// Vector index plus per-vector hold counter; cap marks the capture cycle of a vector.
module sweep_counter
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  output logic [N_IN-1:0] idx,
  output logic            cap,
  output logic            last
);

  localparam logic [HoldW-1:0] SettleHold = HoldW'(SETTLE);
  localparam logic [HoldW-1:0] HoldOne    = HoldW'(1);
  localparam logic [N_IN-1:0]  IdxOne     = N_IN'(1);

  logic [N_IN-1:0]  idx_q;
  logic [HoldW-1:0] hold_q;

  assign cap  = (hold_q == SettleHold);
  assign last = &idx_q;
  assign idx  = idx_q;

  // The terminal vector never wraps: idx stays there so vec_out holds it in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      hold_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      hold_q <= '0;
    end else if (en) begin
      if (cap) begin
        hold_q <= '0;
        if (!last) idx_q <= idx_q + IdxOne;
      end else begin
        hold_q <= hold_q + HoldOne;
      end
    end
  end

endmodule

// File: rtl/truth_sweep.sv
// Sweeps every input vector of a combinational block, captures F into a truth table
// and compares it against a golden table.
module truth_sweep
  import sweep_pkg::*;
#(
  parameter int unsigned        N_IN   = DefNIn,
  parameter int unsigned        SETTLE = 0,
  parameter logic [2**N_IN-1:0] EXPECT = GoldenAbcd
) (
  input  logic          clk,
  input  logic          rst,
  truth_sweep_if.slave  sw
);

  localparam logic [N_IN:0] ErrOne = (N_IN + 1)'(1);

  state_e               state_q;
  logic [2**N_IN-1:0]   table_q;
  logic [N_IN:0]        err_q;
  logic [N_IN-1:0]      ff_q;

  logic [N_IN-1:0]      idx;
  logic                 cap;
  logic                 last;
  logic                 clear;
  logic                 run;

  assign run   = (state_q == StRun);
  assign clear = sw.start && !run;

  sweep_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (run),
    .idx   (idx),
    .cap   (cap),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      table_q <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (sw.start) begin
            state_q <= StRun;
            table_q <= '0;
            err_q   <= '0;
            ff_q    <= '0;
          end
        end
        StRun: begin
          // start is ignored here; only rst can abandon a sweep
          if (cap) begin
            table_q[idx] <= sw.f_in;
            if (sw.f_in != EXPECT[idx]) begin
              err_q <= err_q + ErrOne;
              if (err_q == '0) ff_q <= idx;
            end
            if (last) state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sw.vec_out    = idx;
  assign sw.vec_valid  = run;
  assign sw.busy       = run;
  assign sw.done       = (state_q == StDone);
  assign sw.pass       = (state_q == StDone) && (err_q == '0);
  assign sw.table_out  = table_q;
  assign sw.err_cnt    = err_q;
  assign sw.first_fail = ff_q;

endmodule
